// File: rtl/harris_pkg.sv
// harris_pkg: shared geometry defaults, clog2 helper and packed coordinate type
package harris_pkg;
    localparam int IMG_WIDTH_DEF  = 256;
    localparam int IMG_HEIGHT_DEF = 256;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    localparam int X_W = clog2(IMG_WIDTH_DEF);
    localparam int Y_W = clog2(IMG_HEIGHT_DEF);
    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } coord_t;
endpackage

// File: rtl/corner_coord_fifo.sv
// corner_coord_fifo: first-word-fall-through FIFO with a registered head that reads 0 when empty
module corner_coord_fifo
    import harris_pkg::clog2;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = clog2(DEPTH);
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign dout_o  = head_q;
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
        // the new head may be the slot being written this very edge
        head_d  = (wr_d == rd_d) ? '0 :
                  (do_push && rd_d[AW-1:0] == wr_q[AW-1:0]) ? din_i : mem_q[rd_d[AW-1:0]];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/harris_corner_collector.sv
// harris_corner_collector: tracks raster position of harris_corner results and queues corner coordinates
// for a valid/ready reader, with per-frame counts, frame_done and overflow reporting.
module harris_corner_collector
    import harris_pkg::clog2;
#(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16,
    localparam int X_W       = clog2(IMG_WIDTH),
    localparam int Y_W       = clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             is_corner,
    output logic             coord_valid,
    input  logic             coord_ready,
    output logic [X_W-1:0]   coord_x,
    output logic [Y_W-1:0]   coord_y,
    output logic             frame_done,
    output logic [CNT_W-1:0] corner_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
);
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0] run_q, run_d, cnt_q, cnt_d, drop_q, drop_d;
    logic             ovf_q, fd_q;
    logic             corner, last_x, last, full, empty, pop, drop;
    logic [CNT_W-1:0] run_inc;
    corner_coord_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DATA_W(X_W + Y_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (corner),
        .pop_i  (coord_ready),
        .din_i  ({y_q, x_q}),
        .dout_o ({coord_y, coord_x}),
        .full_o (full),
        .empty_o(empty)
    );
    assign coord_valid  = !empty;
    assign frame_done   = fd_q;
    assign corner_count = cnt_q;
    assign drop_count   = drop_q;
    assign overflow     = ovf_q;
    always_comb begin
        corner  = valid_in && is_corner;
        last_x  = x_q == X_W'(IMG_WIDTH - 1);
        last    = valid_in && last_x && y_q == Y_W'(IMG_HEIGHT - 1);
        pop     = coord_ready && !empty;
        drop    = corner && full && !pop;
        run_inc = (corner && run_q != '1) ? run_q + CNT_W'(1) : run_q;
        x_d     = !valid_in ? x_q : last_x ? '0 : x_q + X_W'(1);
        y_d     = !(valid_in && last_x) ? y_q : last ? '0 : y_q + Y_W'(1);
        run_d   = last ? '0 : run_inc;
        cnt_d   = last ? run_inc : cnt_q;
        drop_d  = (drop && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            run_q  <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_q || drop;
            fd_q   <= last;
        end
    end
endmodule

// File: doc/harris_corner_collector.md
Name: harris_corner_collector

Overview:
- Downstream consumer of the harris_corner output stream (`is_corner` qualified by `valid_out`).
- Tracks the raster position of every valid result.
- Buffers the (x,y) coordinates of detected corners in a small FIFO and presents them on a valid/ready output for a host or DMA reader.
- Reports per-frame corner count, a frame-done pulse and buffer overflow.

Parameters:
- IMG_WIDTH, 256, pixels per line; must match harris_corner.
- IMG_HEIGHT, 256, lines per frame; must match harris_corner.
- FIFO_DEPTH, 16, coordinate FIFO entries; power of two, >= 2.
- CNT_W, 16, width of corner_count and drop_count.
- Localparams: X_W = clog2(IMG_WIDTH), Y_W = clog2(IMG_HEIGHT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  result strobe; driven by harris_corner valid_out.
- is_corner  in  1  corner flag; sampled only when valid_in=1.
- coord_valid  out  1  FIFO head holds a coordinate.
- coord_ready  in  1  consumer accepts head when coord_valid=1.
- coord_x  out  X_W  column of head corner.
- coord_y  out  Y_W  row of head corner.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- corner_count  out  CNT_W  corners detected in last completed frame, including dropped ones.
- drop_count  out  CNT_W  corners lost to FIFO full since reset; saturating.
- overflow  out  1  sticky; set on first drop, cleared only by rst.

Behaviour:
- Reset (async assert, sync release): x=y=0, running count=0, FIFO empty.
  - Outputs at reset: coord_valid=0, coord_x=0, coord_y=0, frame_done=0, corner_count=0, drop_count=0, overflow=0.
- Raster counters advance only on cycles with valid_in=1.
  - x increments; at x=IMG_WIDTH-1, x wraps to 0 and y increments.
  - At x=IMG_WIDTH-1 and y=IMG_HEIGHT-1, both wrap to 0.
  - Gaps in valid_in hold position.
- Push condition: valid_in=1 and is_corner=1. Pushed entry is {x,y} of the current (pre-increment) position.
- FIFO is first-word-fall-through:
  - coord_valid = not empty.
  - coord_x/coord_y show the head.
  - Pop when coord_valid and coord_ready.
  - Head data stays stable while coord_valid=1 and coord_ready=0.
- Latency: a corner sampled at edge N into an empty FIFO gives coord_valid=1 immediately after edge N.
- Full FIFO:
  - Push with a simultaneous pop: push is accepted; occupancy unchanged.
  - Push without a pop: entry dropped, overflow<=1, drop_count increments (saturates at all-ones).
- coord_ready while empty: ignored, no underflow.
- Running count increments on every push condition, whether accepted or dropped; saturates.
- Frame end (valid_in on the last pixel):
  - At that edge, corner_count <= running count plus this pixel's corner.
  - Running count <= 0 at the same edge.
  - frame_done=1 for exactly the following cycle.
- Back-to-back frames need no gap: the first pixel of the next frame may arrive the cycle after the last pixel.
- A push on the last pixel lands in the FIFO in the same edge as frame_done rises.
- Reset mid-frame: FIFO contents and raster position discarded; next valid_in is treated as pixel (0,0).
- coord_x/coord_y are 0 when FIFO is empty (registered head, cleared on empty).

Decomposition:
- Shared package harris_pkg:
  - IMG_WIDTH/IMG_HEIGHT defaults.
  - clog2 function.
  - X_W/Y_W.
  - Packed coordinate typedef {y,x}.
  - Reused by harris_corner and later host-interface blocks.
- Sub-module corner_coord_fifo: synchronous FWFT FIFO.
  - Parameters: DEPTH, DATA_W.
  - Ports: push/pop, full/empty.
  - Wrap-around read/write pointers carrying an extra MSB for full/empty.
- Top holds the raster counters, count/drop logic and frame_done.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, FIFO_DEPTH=4 unless noted):
1. Single corner at pixel index 5, coord_ready=1 -> one transfer x=1,y=1; frame_done pulses one cycle after index 11; corner_count=1.
2. Corners at indices 0,3,4,11, coord_ready=1, valid_in toggling every other cycle -> transfers (0,0),(3,0),(0,1),(3,2) in order; corner_count=4.
3. coord_ready=0, corners at indices 0..5 -> 4 entries held, 2 drops; overflow=1, drop_count=2, corner_count=6; then ready=1 -> (0,0),(1,0),(2,0),(3,0).
4. FIFO full, coord_ready=1 on the same edge a corner arrives -> no drop, occupancy stays 4, overflow stays 0.
5. Two back-to-back frames with 2 then 3 corners -> corner_count=2 after first frame_done, 3 after second; coordinates restart at (0,0).
6. Assert rst mid-frame at index 6 with 2 entries queued -> coord_valid=0 immediately; after release, corner at first pixel reports (0,0).
